// File: rtl/vending_pkg.sv
// vending_pkg: FSM states and coin values (in nickels) shared by the vending controller.
package vending_pkg;
  typedef enum logic [1:0] {IDLE, VEND, PAY} state_t;
  localparam int NICK_VAL = 1;
  localparam int DIME_VAL = 2;
  localparam int QUAR_VAL = 5;
endpackage

// File: rtl/vending_if.sv
// vending_if: coin acceptor, hopper and dispenser signals of the vending controller.
interface vending_if #(parameter int CREDIT_W = 4);
  logic nick_i, dime_i, quar_i, cancel_i, nick_rdy_i;
  logic soda_o, nick_out_o, reject_o, busy_o;
  logic [CREDIT_W-1:0] credit_o;
  modport master (
    output nick_i, dime_i, quar_i, cancel_i, nick_rdy_i,
    input  soda_o, nick_out_o, reject_o, busy_o, credit_o
  );
  modport slave (
    input  nick_i, dime_i, quar_i, cancel_i, nick_rdy_i,
    output soda_o, nick_out_o, reject_o, busy_o, credit_o
  );
endinterface

// File: rtl/vending_payout.sv
// vending_payout: change counter paying one nickel per nick_out/nick_rdy handshake.
module vending_payout #(parameter int CREDIT_W = 4) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_val,
  input  logic                pay,
  input  logic                rdy,
  output logic [CREDIT_W-1:0] change,
  output logic                nick_out,
  output logic                done
);
  logic [CREDIT_W-1:0] change_n;
  assign done = nick_out && rdy && change == CREDIT_W'(1);
  assign change_n = load ? load_val : (nick_out && rdy) ? change - CREDIT_W'(1) : change;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      change   <= '0;
      nick_out <= 1'b0;
    end else begin
      change   <= change_n;
      nick_out <= pay && change_n != '0;
    end
  end
endmodule

// File: rtl/vending_ctrl.sv
// vending_ctrl: credit accumulation, vend FSM and change payout; VEND_REFUND_EN adds cancel/refund.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int PRICE    = 4,
  parameter int CREDIT_W = 4
) (
  input logic      clk,
  input logic      rst,
  vending_if.slave bus
);
  localparam logic [CREDIT_W:0] PRICE_W = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0] MAX_W   = {1'b0, {CREDIT_W{1'b1}}};
  state_t state, next;
  logic [CREDIT_W-1:0] credit, credit_n, load_val, change;
  logic [CREDIT_W:0] val, sum;
  logic any, multi, fits, refund, load, reject_n, done, soda, busy, reject;
  assign any   = bus.nick_i | bus.dime_i | bus.quar_i;
  assign multi = (bus.nick_i & (bus.dime_i | bus.quar_i)) | (bus.dime_i & bus.quar_i);
  assign val   = bus.nick_i ? (CREDIT_W+1)'(NICK_VAL) :
                 bus.dime_i ? (CREDIT_W+1)'(DIME_VAL) :
                 bus.quar_i ? (CREDIT_W+1)'(QUAR_VAL) : '0;
  assign sum   = {1'b0, credit} + val;
  assign fits  = sum <= MAX_W;
`ifdef VEND_REFUND_EN
  assign refund = state == IDLE && bus.cancel_i && credit != '0;
`else
  logic unused;
  assign unused = bus.cancel_i;
  assign refund = 1'b0;
`endif
  always_comb begin
    next     = state;
    credit_n = credit;
    reject_n = any;
    load     = 1'b0;
    load_val = '0;
    if (state == IDLE) begin
      if (refund) begin
        next     = PAY;
        credit_n = '0;
        load     = 1'b1;
        load_val = credit;
      end else begin
        reject_n = multi || (any && !fits);
        if (any && fits) begin
          if (sum >= PRICE_W) begin
            next     = VEND;
            credit_n = '0;
            load     = 1'b1;
            load_val = CREDIT_W'(sum - PRICE_W);
          end else begin
            credit_n = sum[CREDIT_W-1:0];
          end
        end
      end
    end else if (state == VEND) begin
      next = change != '0 ? PAY : IDLE;
    end else if (done || change == '0) begin
      next = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      credit <= '0;
      soda   <= 1'b0;
      busy   <= 1'b0;
      reject <= 1'b0;
    end else begin
      state  <= next;
      credit <= credit_n;
      soda   <= next == VEND;
      busy   <= next != IDLE;
      reject <= reject_n;
    end
  end
  vending_payout #(.CREDIT_W(CREDIT_W)) u_payout (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_val(load_val),
    .pay(next == PAY),
    .rdy(bus.nick_rdy_i),
    .change(change),
    .nick_out(bus.nick_out_o),
    .done(done)
  );
  assign bus.credit_o = credit;
  assign bus.soda_o   = soda;
  assign bus.busy_o   = busy;
  assign bus.reject_o = reject;
endmodule

// File: tb/tb_vending_ctrl.sv
// tb_vending_ctrl: directed scoreboard bench; a PRICE=4 unit plus a PRICE=15 unit for credit saturation.
module tb_vending_ctrl;
  typedef struct packed {
    logic [3:0] credit;
    logic       soda, nout, rej, busy;
  } exp_t;
  localparam logic [2:0] Z = 3'b000, N = 3'b100, D = 3'b010, Q = 3'b001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int passes = 0, fails = 0, total = 0;
  always #5 clk = ~clk;
  vending_if #(.CREDIT_W(4)) a ();
  vending_if #(.CREDIT_W(4)) b ();
  vending_ctrl #(.PRICE(4), .CREDIT_W(4)) dut (.clk(clk), .rst(rst), .bus(a));
  vending_ctrl #(.PRICE(15), .CREDIT_W(4)) dut_sat (.clk(clk), .rst(rst), .bus(b));

  task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check(input bit sel, input string tag);
    exp_t e, o;
    e = q.pop_front();
    o = sel ? '{b.credit_o, b.soda_o, b.nick_out_o, b.reject_o, b.busy_o}
            : '{a.credit_o, a.soda_o, a.nick_out_o, a.reject_o, a.busy_o};
    cmp({tag, ".credit"}, o.credit, e.credit);
    cmp({tag, ".soda"}, {3'b0, o.soda}, {3'b0, e.soda});
    cmp({tag, ".nick_out"}, {3'b0, o.nout}, {3'b0, e.nout});
    cmp({tag, ".reject"}, {3'b0, o.rej}, {3'b0, e.rej});
    cmp({tag, ".busy"}, {3'b0, o.busy}, {3'b0, e.busy});
  endtask

  // Drive one cycle of stimulus on unit sel, then compare the following cycle's outputs.
  task automatic step(input bit sel, input string tag, input logic [2:0] c, input logic r, input logic x,
                      input logic [3:0] ec, input logic es, input logic en, input logic ej, input logic eb);
    @(negedge clk);
    if (sel) begin
      {b.nick_i, b.dime_i, b.quar_i} = c;
      b.nick_rdy_i = r;
      b.cancel_i = x;
    end else begin
      {a.nick_i, a.dime_i, a.quar_i} = c;
      a.nick_rdy_i = r;
      a.cancel_i = x;
    end
    q.push_back('{ec, es, en, ej, eb});
    @(posedge clk);
    #1;
    {a.nick_i, a.dime_i, a.quar_i, a.cancel_i} = 4'b0;
    {b.nick_i, b.dime_i, b.quar_i, b.cancel_i} = 4'b0;
    check(sel, tag);
  endtask

  initial begin
    {a.nick_i, a.dime_i, a.quar_i, a.cancel_i} = 4'b0;
    {b.nick_i, b.dime_i, b.quar_i, b.cancel_i} = 4'b0;
    a.nick_rdy_i = 1'b1;
    b.nick_rdy_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    q.push_back('0);
    check(0, "reset_a");
    q.push_back('0);
    check(1, "reset_b");
    @(negedge clk);
    rst = 1'b0;
    step(0, "quar_vend", Q, 1, 0, 0, 1, 0, 0, 1);
    step(0, "quar_pay", Z, 1, 0, 0, 0, 1, 0, 1);
    step(0, "quar_done", Z, 1, 0, 0, 0, 0, 0, 0);
    step(0, "nick1", N, 1, 0, 1, 0, 0, 0, 0);
    step(0, "dime3", D, 1, 0, 3, 0, 0, 0, 0);
    step(0, "nick_vend", N, 1, 0, 0, 1, 0, 0, 1);
    step(0, "exact_idle", Z, 1, 0, 0, 0, 0, 0, 0);
    step(0, "nick_quar", N | Q, 1, 0, 1, 0, 0, 1, 0);
    step(0, "rej_clear", Z, 1, 0, 1, 0, 0, 0, 0);
    step(0, "dime_to3", D, 1, 0, 3, 0, 0, 0, 0);
    step(0, "q_chg4", Q, 0, 0, 0, 1, 0, 0, 1);
    step(0, "pay4_wait", Z, 0, 0, 0, 0, 1, 0, 1);
    step(0, "pay_hs1", Z, 1, 0, 0, 0, 1, 0, 1);
    step(0, "pay_coin", D, 0, 0, 0, 0, 1, 1, 1);
    step(0, "pay_hs2", Z, 1, 0, 0, 0, 1, 0, 1);
    step(0, "pay_hold2", Z, 0, 0, 0, 0, 1, 0, 1);
    step(0, "pay_hs3", Z, 1, 0, 0, 0, 1, 0, 1);
    step(0, "pay_hold3", Z, 0, 0, 0, 0, 1, 0, 1);
    step(0, "pay_hs4", Z, 1, 0, 0, 0, 0, 0, 0);
    step(0, "post_pay", Z, 1, 0, 0, 0, 0, 0, 0);
    step(0, "cr_nick", N, 1, 0, 1, 0, 0, 0, 0);
    step(0, "cr_dime", D, 1, 0, 3, 0, 0, 0, 0);
`ifdef VEND_REFUND_EN
    step(0, "cancel", D, 1, 1, 0, 0, 1, 1, 1);
    step(0, "refund1", Z, 1, 0, 0, 0, 1, 0, 1);
    step(0, "refund2", Z, 1, 0, 0, 0, 1, 0, 1);
    step(0, "refund3", Z, 1, 0, 0, 0, 0, 0, 0);
`else
    step(0, "cancel_ign", D, 1, 1, 0, 1, 0, 0, 1);
    step(0, "cancel_pay", Z, 1, 0, 0, 0, 1, 0, 1);
    step(0, "cancel_done", Z, 1, 0, 0, 0, 0, 0, 0);
`endif
    step(0, "rs_dime", D, 1, 0, 2, 0, 0, 0, 0);
    step(0, "rs_quar", Q, 0, 0, 0, 1, 0, 0, 1);
    step(0, "rs_pay", Z, 0, 0, 0, 0, 1, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    q.push_back('0);
    check(0, "async_rst");
    @(negedge clk);
    rst = 1'b0;
    a.nick_rdy_i = 1'b1;
    step(0, "rst_idle", Z, 1, 0, 0, 0, 0, 0, 0);
    step(0, "rst_coin", N, 1, 0, 1, 0, 0, 0, 0);
    step(1, "sat_q5", Q, 1, 0, 5, 0, 0, 0, 0);
    step(1, "sat_q10", Q, 1, 0, 10, 0, 0, 0, 0);
    step(1, "sat_d12", D, 1, 0, 12, 0, 0, 0, 0);
    step(1, "sat_d14", D, 1, 0, 14, 0, 0, 0, 0);
    step(1, "sat_over", D, 1, 0, 14, 0, 0, 1, 0);
    step(1, "sat_n15", N, 1, 0, 0, 1, 0, 0, 1);
    step(1, "sat_idle", Z, 1, 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
